// File: rtl/lives_tracker.sv
`default_nettype none
// ============================================================================
// Module   : lives_tracker
// Brief    : Turns stomp events into lives, respawn and invulnerability timing,
//            plus the game-over / winner result.
// Revision : 1.0
// ============================================================================
module lives_tracker #(
  parameter int START_LIVES    = 3,
  parameter int RESPAWN_FRAMES = 30,
  parameter int INVULN_FRAMES  = 60
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       vs,
  input  logic       start_game,
  input  logic       hit0,
  input  logic       hit1,
  output logic [2:0] lives0,
  output logic [2:0] lives1,
  output logic       invuln0,
  output logic       invuln1,
  output logic       respawn0,
  output logic       respawn1,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [1:0] state_out
);

  localparam int C_MAXF = (RESPAWN_FRAMES > INVULN_FRAMES) ? RESPAWN_FRAMES : INVULN_FRAMES;
  localparam int C_CW   = $clog2(C_MAXF + 1);

  localparam logic [C_CW-1:0] C_RESPAWN = C_CW'(RESPAWN_FRAMES);
  localparam logic [C_CW-1:0] C_INVULN  = C_CW'(INVULN_FRAMES);
  localparam logic [C_CW-1:0] C_ONE     = C_CW'(1);
  localparam logic [2:0]      C_START   = 3'(START_LIVES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PLAY    = 2'd1,
    S_RESPAWN = 2'd2,
    S_OVER    = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_vs_q, r_hit0_q, r_hit1_q;
  logic [2:0]        r_lives0, r_lives1, w_lives0_nxt, w_lives1_nxt;
  logic [C_CW-1:0]   r_inv0, r_inv1, w_inv0_nxt, w_inv1_nxt;
  logic [C_CW-1:0]   r_frame, w_frame_nxt;
  logic              r_victim0, r_victim1, w_victim0_nxt, w_victim1_nxt;
  logic              r_respawn0, r_respawn1, w_respawn0_nxt, w_respawn1_nxt;

  logic              w_tick, w_ev0, w_ev1, w_cnt0, w_cnt1;
  logic [2:0]        w_dec0, w_dec1;

  // w_cnt0/w_cnt1 mean "player 0/1 loses a life this cycle".
  always_comb begin
    w_tick = vs & ~r_vs_q;
    w_ev0  = hit0 & ~r_hit0_q;
    w_ev1  = hit1 & ~r_hit1_q;
    w_cnt0 = w_ev1 && (r_state == S_PLAY) && (r_inv0 == '0);
    w_cnt1 = w_ev0 && (r_state == S_PLAY) && (r_inv1 == '0);
    w_dec0 = (r_lives0 != 3'd0) ? (r_lives0 - 3'd1) : 3'd0;
    w_dec1 = (r_lives1 != 3'd0) ? (r_lives1 - 3'd1) : 3'd0;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_lives0_nxt   = r_lives0;
    w_lives1_nxt   = r_lives1;
    w_inv0_nxt     = r_inv0;
    w_inv1_nxt     = r_inv1;
    w_frame_nxt    = r_frame;
    w_victim0_nxt  = r_victim0;
    w_victim1_nxt  = r_victim1;
    w_respawn0_nxt = 1'b0;
    w_respawn1_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_lives0_nxt = C_START;
        w_lives1_nxt = C_START;
        w_inv0_nxt   = '0;
        w_inv1_nxt   = '0;
        if (start_game) w_state_nxt = S_PLAY;
      end
      S_PLAY: begin
        if (w_tick) begin
          if (r_inv0 != '0) w_inv0_nxt = r_inv0 - C_ONE;
          if (r_inv1 != '0) w_inv1_nxt = r_inv1 - C_ONE;
        end
        if (w_cnt0 || w_cnt1) begin
          if (w_cnt0) w_lives0_nxt = w_dec0;
          if (w_cnt1) w_lives1_nxt = w_dec1;
          // A fatal hit skips respawn entirely, even for a surviving co-victim.
          if ((w_cnt0 && (w_dec0 == 3'd0)) || (w_cnt1 && (w_dec1 == 3'd0))) begin
            w_state_nxt = S_OVER;
          end else begin
            w_state_nxt    = S_RESPAWN;
            w_frame_nxt    = C_RESPAWN;
            w_victim0_nxt  = w_cnt0;
            w_victim1_nxt  = w_cnt1;
            w_respawn0_nxt = w_cnt0;
            w_respawn1_nxt = w_cnt1;
          end
        end
      end
      S_RESPAWN: begin
        if (w_tick) begin
          if (r_frame == C_ONE) begin
            w_state_nxt = S_PLAY;
            w_frame_nxt = '0;
            if (r_victim0) w_inv0_nxt = C_INVULN;
            if (r_victim1) w_inv1_nxt = C_INVULN;
          end else begin
            w_frame_nxt = r_frame - C_ONE;
          end
        end
      end
      S_OVER: begin
        if (start_game) begin
          w_state_nxt  = S_PLAY;
          w_lives0_nxt = C_START;
          w_lives1_nxt = C_START;
          w_inv0_nxt   = '0;
          w_inv1_nxt   = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_vs_q     <= 1'b0;
      r_hit0_q   <= 1'b0;
      r_hit1_q   <= 1'b0;
      r_lives0   <= C_START;
      r_lives1   <= C_START;
      r_inv0     <= '0;
      r_inv1     <= '0;
      r_frame    <= '0;
      r_victim0  <= 1'b0;
      r_victim1  <= 1'b0;
      r_respawn0 <= 1'b0;
      r_respawn1 <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_vs_q     <= vs;
      r_hit0_q   <= hit0;
      r_hit1_q   <= hit1;
      r_lives0   <= w_lives0_nxt;
      r_lives1   <= w_lives1_nxt;
      r_inv0     <= w_inv0_nxt;
      r_inv1     <= w_inv1_nxt;
      r_frame    <= w_frame_nxt;
      r_victim0  <= w_victim0_nxt;
      r_victim1  <= w_victim1_nxt;
      r_respawn0 <= w_respawn0_nxt;
      r_respawn1 <= w_respawn1_nxt;
    end
  end

  always_comb begin
    lives0    = r_lives0;
    lives1    = r_lives1;
    invuln0   = (r_inv0 != '0);
    invuln1   = (r_inv1 != '0);
    respawn0  = r_respawn0;
    respawn1  = r_respawn1;
    game_over = (r_state == S_OVER);
    winner    = (r_state == S_OVER) ? {r_lives0 == 3'd0, r_lives1 == 3'd0} : 2'b00;
    state_out = r_state;
  end

endmodule
`default_nettype wire

// File: tb/tb_lives_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_lives_tracker
// Brief    : Directed vector table plus hand-written frame sequences.
// Revision : 1.0
// ============================================================================
module tb_lives_tracker;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       vs = 1'b0;
  logic       start_game = 1'b0;
  logic       hit0 = 1'b0;
  logic       hit1 = 1'b0;
  logic [2:0] lives0, lives1;
  logic       invuln0, invuln1, respawn0, respawn1, game_over;
  logic [1:0] winner, state_out;

  int n_cmp = 0;
  int n_err = 0;

  always #10 Clk = ~Clk;

  lives_tracker #(.START_LIVES(3), .RESPAWN_FRAMES(30), .INVULN_FRAMES(60)) dut (
    .Clk(Clk), .Reset(Reset), .vs(vs), .start_game(start_game),
    .hit0(hit0), .hit1(hit1), .lives0(lives0), .lives1(lives1),
    .invuln0(invuln0), .invuln1(invuln1), .respawn0(respawn0), .respawn1(respawn1),
    .game_over(game_over), .winner(winner), .state_out(state_out)
  );

  // Observed layout: lives0 lives1 state respawn0 respawn1 invuln0 invuln1 game_over winner
  logic [14:0] w_obs;
  assign w_obs = {lives0, lives1, state_out, respawn0, respawn1, invuln0, invuln1, game_over, winner};

  function automatic logic [14:0] ex(input logic [2:0] l0, input logic [2:0] l1,
                                     input logic [1:0] st, input logic r0, input logic r1,
                                     input logic i0, input logic i1, input logic go,
                                     input logic [1:0] w);
    return {l0, l1, st, r0, r1, i0, i1, go, w};
  endfunction

  task automatic check(input string name, input logic [14:0] e);
    n_cmp++;
    if (w_obs !== e) begin
      n_err++;
      $display("FAIL %s: got l0=%0d l1=%0d st=%0d rsp=%b%b inv=%b%b go=%b win=%b, want l0=%0d l1=%0d st=%0d rsp=%b%b inv=%b%b go=%b win=%b",
               name, w_obs[14:12], w_obs[11:9], w_obs[8:7], w_obs[6], w_obs[5], w_obs[4], w_obs[3], w_obs[2], w_obs[1:0],
               e[14:12], e[11:9], e[8:7], e[6], e[5], e[4], e[3], e[2], e[1:0]);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      vs = 1'b1;
      cyc();
      vs = 1'b0;
      cyc();
    end
  endtask

  typedef struct packed {
    logic        rst;
    logic        start;
    logic        h0;
    logic        h1;
    logic [14:0] exp;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, ex(3, 3, 0, 0, 0, 0, 0, 0, 2'b00)};
    for (int i = 1; i <= 5; i++)
      tbl[i] = '{1'b0, 1'b0, 1'b0, 1'b0, ex(3, 3, 0, 0, 0, 0, 0, 0, 2'b00)};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, ex(3, 3, 1, 0, 0, 0, 0, 0, 2'b00)};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, ex(3, 2, 2, 0, 1, 0, 0, 0, 2'b00)};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, ex(3, 2, 2, 0, 0, 0, 0, 0, 2'b00)};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, ex(3, 2, 2, 0, 0, 0, 0, 0, 2'b00)};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, ex(3, 2, 2, 0, 0, 0, 0, 0, 2'b00)};

    #1;
    for (int i = 0; i < 11; i++) begin
      Reset      = tbl[i].rst;
      start_game = tbl[i].start;
      hit0       = tbl[i].h0;
      hit1       = tbl[i].h1;
      cyc();
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Respawn lasts exactly 30 ticks, then victim immune for exactly 60.
    frames(29);
    check("respawn_29", ex(3, 2, 2, 0, 0, 0, 0, 0, 2'b00));
    frames(1);
    check("respawn_30", ex(3, 2, 1, 0, 0, 0, 1, 0, 2'b00));
    hit0 = 1'b1; cyc();
    check("hit_while_invuln", ex(3, 2, 1, 0, 0, 0, 1, 0, 2'b00));
    hit0 = 1'b0; cyc();
    frames(59);
    check("invuln_59", ex(3, 2, 1, 0, 0, 0, 1, 0, 2'b00));
    frames(1);
    check("invuln_60", ex(3, 2, 1, 0, 0, 0, 0, 0, 2'b00));

    // Held hit level counts once, including across RESPAWN.
    hit0 = 1'b1; cyc();
    check("held_first", ex(3, 1, 2, 0, 1, 0, 0, 0, 2'b00));
    repeat (499) cyc();
    check("held_500", ex(3, 1, 2, 0, 0, 0, 0, 0, 2'b00));
    frames(30);
    check("held_back_play", ex(3, 1, 1, 0, 0, 0, 1, 0, 2'b00));
    repeat (20) cyc();
    check("held_in_play", ex(3, 1, 1, 0, 0, 0, 1, 0, 2'b00));
    hit0 = 1'b0; cyc();

    // Three counted hit1 events drain player 0.
    hit1 = 1'b1; cyc();
    check("p0_hit1", ex(2, 1, 2, 1, 0, 0, 1, 0, 2'b00));
    hit1 = 1'b0; cyc();
    frames(30);
    check("p0_hit1_play", ex(2, 1, 1, 0, 0, 1, 1, 0, 2'b00));
    frames(60);
    check("p0_hit1_clear", ex(2, 1, 1, 0, 0, 0, 0, 0, 2'b00));
    hit1 = 1'b1; cyc();
    check("p0_hit2", ex(1, 1, 2, 1, 0, 0, 0, 0, 2'b00));
    hit1 = 1'b0; cyc();
    frames(30);
    check("p0_hit2_play", ex(1, 1, 1, 0, 0, 1, 0, 0, 2'b00));
    frames(60);
    hit1 = 1'b1; cyc();
    check("p0_fatal", ex(0, 1, 3, 0, 0, 0, 0, 1, 2'b10));
    hit1 = 1'b0; repeat (3) cyc();
    check("over_hold", ex(0, 1, 3, 0, 0, 0, 0, 1, 2'b10));
    start_game = 1'b1; cyc();
    check("restart", ex(3, 3, 1, 0, 0, 0, 0, 0, 2'b00));
    start_game = 1'b0;

    // Simultaneous hits down to a draw.
    hit0 = 1'b1; hit1 = 1'b1; cyc();
    check("both_1", ex(2, 2, 2, 1, 1, 0, 0, 0, 2'b00));
    hit0 = 1'b0; hit1 = 1'b0; cyc();
    frames(30);
    check("both_1_play", ex(2, 2, 1, 0, 0, 1, 1, 0, 2'b00));
    frames(60);
    hit0 = 1'b1; hit1 = 1'b1; cyc();
    check("both_2", ex(1, 1, 2, 1, 1, 0, 0, 0, 2'b00));
    hit0 = 1'b0; hit1 = 1'b0; cyc();
    frames(30);
    frames(60);
    check("both_2_clear", ex(1, 1, 1, 0, 0, 0, 0, 0, 2'b00));
    hit0 = 1'b1; hit1 = 1'b1; cyc();
    check("draw", ex(0, 0, 3, 0, 0, 0, 0, 1, 2'b11));
    hit0 = 1'b0; hit1 = 1'b0; cyc();
    check("draw_no_pulse", ex(0, 0, 3, 0, 0, 0, 0, 1, 2'b11));

    // Reset mid-RESPAWN.
    start_game = 1'b1; cyc();
    start_game = 1'b0;
    hit0 = 1'b1; cyc();
    check("pre_reset_hit", ex(3, 2, 2, 0, 1, 0, 0, 0, 2'b00));
    hit0 = 1'b0;
    frames(10);
    Reset = 1'b1; cyc();
    check("reset_mid_respawn", ex(3, 3, 0, 0, 0, 0, 0, 0, 2'b00));
    Reset = 1'b0; cyc();
    check("after_reset", ex(3, 3, 0, 0, 0, 0, 0, 0, 2'b00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
